// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings,
// request field widths and the byte-merge helper.
package dm_responder_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  localparam int DM_XLEN  = 32;
  localparam int DM_BE_W  = DM_XLEN / 8;
  localparam int DM_CNT_W = 4;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w
  function automatic logic [DM_XLEN-1:0] dm_merge(input logic [DM_XLEN-1:0] old_w,
                                                  input logic [DM_XLEN-1:0] new_w,
                                                  input logic [DM_BE_W-1:0] be);
    logic [DM_XLEN-1:0] m;
    m = old_w;
    for (int b = 0; b < DM_BE_W; b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Word array: synchronous byte-enable write, combinational read,
// synchronous active-low clear of every word.
module dm_word_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Clear wins over write; otherwise write only the enabled bytes
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder. One request at a time: accept in IDLE,
// count down LATENCY cycles in WAIT, then access the array on the first RESP
// cycle and hold the registered response until the requester takes it.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [DM_CNT_W-1:0] CNT_INIT =
    (LATENCY > 0) ? DM_CNT_W'(LATENCY - 1) : '0;

  dm_state_e             state_q, state_d;
  logic [DM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [DM_XLEN-1:0]    addr_q, addr_d;
  logic [DM_XLEN-1:0]    wdata_q, wdata_d;
  logic [DM_BE_W-1:0]    be_q, be_d;
  logic [DM_XLEN-1:0]    pc_q, pc_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DM_XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DM_XLEN-1:0]    ram_rdata;
  logic                  misaligned, out_of_range, acc_err;
  logic                  resp_entry, ram_we;
  logic [AW-1:0]         word_idx;

  // Errors are judged on the latched request; upper address bits only feed the range check
  assign misaligned   = (addr_q[1:0] != 2'b00);
  assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign acc_err      = misaligned | out_of_range;
  assign word_idx     = addr_q[AW+1:2];

  // First RESP cycle is the single point where the array is read or written
  assign resp_entry = (state_q == DM_RESP) && !rsp_valid_q;
  assign ram_we     = resp_entry && wr_q && !acc_err;

  dm_word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .clr_n (reset),
    .we    (ram_we),
    .waddr (word_idx),
    .wdata (wdata_q),
    .wbe   (be_q),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  // Next-state and next-output logic for the request/response FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    pc_d        = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      DM_IDLE: begin
        if (req_valid && req_ready_q) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          pc_d    = req_pc;
          if (LATENCY == 0) begin
            state_d = DM_RESP;
          end else begin
            state_d = DM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DM_WAIT: begin
        if (cnt_q == '0) state_d = DM_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DM_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (acc_err || wr_q) ? '0 : ram_rdata;
          rsp_err_d   = acc_err;
        end else if (rsp_ready) begin
          state_d     = DM_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = DM_IDLE;
    endcase
    // Ready is registered, so the cycle after a response handshake is the earliest accept
    req_ready_d = (state_d == DM_IDLE);
  end

  // State registers; reset drops any in-flight request without a response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= DM_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      pc_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      pc_q        <= pc_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifndef SYNTHESIS
  // Store log: the full word as it reads after the byte merge
  always_ff @(posedge clk) begin
    if (reset && ram_we)
      $display("@%h: *%h <= %h", pc_q, addr_q, dm_merge(ram_rdata, wdata_q, be_q));
  end
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
